// File: rtl/tmr_pkg.sv
// tmr_pkg: shared source-type constants, FSM state type and source-index helper
package tmr_pkg;
  localparam int SRC_CMIA = 0;
  localparam int SRC_CMIB = 1;
  localparam int SRC_OVI  = 2;
  typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_t;
  function automatic int src_idx(input int ch, input int typ);
    return ch * 3 + typ;
  endfunction
endpackage

// File: rtl/tmr_prio_enc.sv
// tmr_prio_enc: combinational priority encoder, lowest set index wins
module tmr_prio_enc #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
endmodule

// File: rtl/tmr_irq_ctrl.sv
// tmr_irq_ctrl: timer interrupt flags, lost-event tracking and one-at-a-time
// request/acknowledge handshake towards the CPU
module tmr_irq_ctrl
  import tmr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int NSRC   = 3 * NUM_CH,
  parameter int VEC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] cmia,
  input  logic [NUM_CH-1:0] cmib,
  input  logic [NUM_CH-1:0] ovi,
  input  logic [NSRC-1:0]   ier,
  input  logic [NSRC-1:0]   clr,
  input  logic              irq_ack,
  output logic              irq_req,
  output logic [VEC_W-1:0]  irq_vec,
  output logic [NSRC-1:0]   flag,
  output logic [NSRC-1:0]   lost
);
  logic [NSRC-1:0] src_in, src_q, src_d, ev, ack_clr, flag_n;
  logic [VEC_W-1:0] pend_idx;
  logic pend_vld, armed;
  irq_state_t state;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_map
    assign src_in[src_idx(c, SRC_CMIA)] = cmia[c];
    assign src_in[src_idx(c, SRC_CMIB)] = cmib[c];
    assign src_in[src_idx(c, SRC_OVI)]  = ovi[c];
  end
  // First edge after reset seeds the history with the live inputs so a level
  // already high across reset is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q <= '0;
      src_d <= '0;
      armed <= 1'b0;
    end else begin
      src_q <= src_in;
      src_d <= armed ? src_q : src_in;
      armed <= 1'b1;
    end
  end
  assign ev      = src_q & ~src_d;
  assign ack_clr = (state == REQ && irq_ack) ? NSRC'(1) << irq_vec : '0;
  assign flag_n  = ev | (flag & ~clr & ~ack_clr);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag <= '0;
      lost <= '0;
    end else begin
      flag <= flag_n;
      lost <= (ev & flag) | (lost & ~clr);
    end
  end
  tmr_prio_enc #(.N(NSRC), .W(VEC_W)) u_prio (
    .req  (flag & ier),
    .valid(pend_vld),
    .idx  (pend_idx)
  );
  // Withdrawal looks at the next flag value so a clear drops the request on
  // the same edge that clears the flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      irq_vec <= '0;
    end else begin
      case (state)
        IDLE: if (pend_vld) begin
          irq_vec <= pend_idx;
          irq_req <= 1'b1;
          state   <= REQ;
        end
        REQ: if (irq_ack) begin
          irq_req <= 1'b0;
          state   <= GAP;
        end else if (!(flag_n[irq_vec] && ier[irq_vec])) begin
          irq_req <= 1'b0;
          state   <= IDLE;
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
